fir_stream_checker: RTL

- In-line streaming response checker for the N-tap FIR filter.
- Taps the same sample stream fed to the filter (`data_in`) and the filter output (`data_out`).
- Recomputes the expected output with its own delay line and accumulator, aligns it to the filter latency, and flags mismatches.
- Sits beside the filter in benches and in the on-chip self-test wrapper.

---
 rtl/fir_stream_checker.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fir_stream_checker.sv
// In-line response checker for an N-tap FIR: recomputes the expected output, aligns it
// to the filter latency and flags mismatches. Define FIR_CHK_STOP_ON_ERR_EN to halt on the first error.
module fir_stream_checker #(
    parameter int                       N           = 4,
    parameter int                       COEFF_WIDTH = 8,
    parameter int                       DATA_WIDTH  = 8,
    parameter int                       ACC_WIDTH   = 16,
    parameter logic [N*COEFF_WIDTH-1:0] COEFFS      = {8'd1, 8'd2, 8'd3, 8'd4},
    parameter int                       LATENCY     = 1,
    parameter int                       CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  mismatch,
    output logic                  error_flag,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [CNT_WIDTH-1:0]  sample_count,
    output logic [DATA_WIDTH-1:0] first_exp,
    output logic [DATA_WIDTH-1:0] first_got,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FILL  = 2'b01,
        S_CHECK = 2'b10,
        S_HALT  = 2'b11
    } state_t;

    state_t                                r_state;
    logic [N-2:0][DATA_WIDTH-1:0]          r_dly;
    logic [LATENCY-1:0][DATA_WIDTH-1:0]    r_exp_pipe;
    logic [LATENCY-1:0]                    r_vld_pipe;
    logic                                  r_mismatch;
    logic                                  r_err_flag;
    logic [CNT_WIDTH-1:0]                  r_err_cnt;
    logic [CNT_WIDTH-1:0]                  r_smp_cnt;
    logic [DATA_WIDTH-1:0]                 r_first_exp;
    logic [DATA_WIDTH-1:0]                 r_first_got;

    logic [N-1:0][DATA_WIDTH-1:0]          w_taps;
    logic [ACC_WIDTH-1:0]                  w_acc;
    logic [DATA_WIDTH-1:0]                 w_exp;
    logic                                  w_run;
    logic                                  w_head_vld;
    logic                                  w_diff;

    // w_taps[k] is x[n-k]: current sample in slot 0, history above it
    assign w_taps = {r_dly, data_in};

    always_comb begin
        w_acc = '0;
        for (int k = 0; k < N; k++) begin
            w_acc = w_acc +
                ({{(ACC_WIDTH-COEFF_WIDTH){COEFFS[k*COEFF_WIDTH+COEFF_WIDTH-1]}},
                  COEFFS[k*COEFF_WIDTH +: COEFF_WIDTH]} *
                 {{(ACC_WIDTH-DATA_WIDTH){w_taps[k][DATA_WIDTH-1]}}, w_taps[k]});
        end
    end

    // Plain truncation matches a filter that wraps its output
    assign w_exp      = w_acc[DATA_WIDTH-1:0];
    assign w_run      = enable && (r_state != S_HALT);
    assign w_head_vld = r_vld_pipe[LATENCY-1];
    assign w_diff     = (data_out != r_exp_pipe[LATENCY-1]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_dly       <= '0;
            r_exp_pipe  <= '0;
            r_vld_pipe  <= '0;
            r_mismatch  <= 1'b0;
            r_err_flag  <= 1'b0;
            r_err_cnt   <= '0;
            r_smp_cnt   <= '0;
            r_first_exp <= '0;
            r_first_got <= '0;
        end else begin
            r_mismatch <= 1'b0;
            // History keeps tracking the filter across clear so later compares stay aligned
            if (w_run)
                r_dly <= w_taps[N-2:0];

            if (clear) begin
                r_err_flag  <= 1'b0;
                r_err_cnt   <= '0;
                r_smp_cnt   <= '0;
                r_first_exp <= '0;
                r_first_got <= '0;
                r_vld_pipe  <= '0;
                r_state     <= enable ? S_FILL : S_IDLE;
            end else if (r_state != S_HALT) begin
                if (!enable) begin
                    r_vld_pipe <= '0;
                    r_state    <= S_IDLE;
                end else begin
                    for (int i = LATENCY-1; i > 0; i--) begin
                        r_exp_pipe[i] <= r_exp_pipe[i-1];
                        r_vld_pipe[i] <= r_vld_pipe[i-1];
                    end
                    r_exp_pipe[0] <= w_exp;
                    r_vld_pipe[0] <= 1'b1;

                    if (r_state == S_IDLE)
                        r_state <= S_FILL;

                    // First valid head marks the end of FILL and is itself compared
                    if (w_head_vld) begin
                        r_state   <= S_CHECK;
                        r_smp_cnt <= (r_smp_cnt == '1) ? r_smp_cnt : r_smp_cnt + 1'b1;
                        if (w_diff) begin
                            r_mismatch <= 1'b1;
                            r_err_flag <= 1'b1;
                            r_err_cnt  <= (r_err_cnt == '1) ? r_err_cnt : r_err_cnt + 1'b1;
                            if (!r_err_flag) begin
                                r_first_exp <= r_exp_pipe[LATENCY-1];
                                r_first_got <= data_out;
                            end
`ifdef FIR_CHK_STOP_ON_ERR_EN
                            r_state <= S_HALT;
`endif
                        end
                    end
                end
            end
        end
    end

    assign mismatch     = r_mismatch;
    assign error_flag   = r_err_flag;
    assign err_count    = r_err_cnt;
    assign sample_count = r_smp_cnt;
    assign first_exp    = r_first_exp;
    assign first_got    = r_first_got;
    assign state        = r_state;

endmodule
